game_status_manager: RTL

Sequential stage directly downstream of the game FSM. It consumes that FSM's one-cycle `win`/`lose` pulses and owns the game's session state: lives, level, score and post-event banner hold. It drives frog/object restart and a per-level speed to the object movers, and a banner code to the screen overlay. It also filters the FSM's spurious pulses: a `lose` after reset, and repeated hits while the frog still overlaps an object.

---
 rtl/game_pkg.sv | 29 ++
 rtl/frame_hold_counter.sv | 25 ++
 rtl/game_status_manager.sv | 123 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game session logic.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_HOLD_WIN,
    ST_HOLD_LOSE,
    ST_GAME_OVER
  } game_state_t;

  localparam logic [1:0] BANNER_NONE = 2'd0;
  localparam logic [1:0] BANNER_WIN  = 2'd1;
  localparam logic [1:0] BANNER_LOSE = 2'd2;
  localparam logic [1:0] BANNER_OVER = 2'd3;

  localparam int LIVES_INIT_DEF = 3;
  localparam int MAX_LEVEL_DEF  = 7;

  function automatic logic [1:0] banner_of(input game_state_t st);
    case (st)
      ST_HOLD_WIN:  banner_of = BANNER_WIN;
      ST_HOLD_LOSE: banner_of = BANNER_LOSE;
      ST_GAME_OVER: banner_of = BANNER_OVER;
      default:      banner_of = BANNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_hold_counter.sv
// Counts start_of_frame pulses while not cleared; done fires on the HOLD_FRAMES-th pulse.
module frame_hold_counter #(
  parameter int HOLD_FRAMES = 60
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic start_of_frame,
  output logic done
);

  localparam int CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_FRAMES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)             cnt <= '0;
    else if (clear)          cnt <= '0;
    else if (start_of_frame) cnt <= cnt + 1'b1;
  end

  assign done = ~clear & start_of_frame & (cnt == LAST);

endmodule

// File: rtl/game_status_manager.sv
// Session state downstream of the game FSM: lives, level, score, banner hold and restart.
module game_status_manager
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = LIVES_INIT_DEF,
  parameter int MAX_LEVEL   = MAX_LEVEL_DEF,
  parameter int HOLD_FRAMES = 60,
  parameter int SCORE_W     = 10
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start_of_frame,
  input  logic               win,
  input  logic               lose,
  input  logic               start_key,
  output logic               run,
  output logic               frog_restart,
  output logic [3:0]         speed,
  output logic [1:0]         lives,
  output logic [2:0]         level,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         banner,
  output logic               game_over
);

  game_state_t        state, state_nxt;
  logic [1:0]         lives_nxt;
  logic [2:0]         level_nxt, level_inc;
  logic [SCORE_W-1:0] score_nxt, score_win;
  logic [SCORE_W:0]   score_sum;
  logic               restart_nxt;
  logic               key_q, start_edge;
  logic               hold_clear, hold_done;

  // Edge flop resets high so a key held through reset is not a press.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) key_q <= 1'b1;
    else         key_q <= start_key;
  end
  assign start_edge = start_key & ~key_q;

  assign hold_clear = (state != ST_HOLD_WIN) && (state != ST_HOLD_LOSE);

  frame_hold_counter #(.HOLD_FRAMES(HOLD_FRAMES)) u_hold (
    .clk            (clk),
    .resetN         (resetN),
    .clear          (hold_clear),
    .start_of_frame (start_of_frame),
    .done           (hold_done)
  );

  assign score_sum = {1'b0, score} + (SCORE_W+1)'(level) + 1'b1;
  assign score_win = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign level_inc = (level >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : level + 3'd1;

  always_comb begin
    state_nxt   = state;
    lives_nxt   = lives;
    level_nxt   = level;
    score_nxt   = score;
    restart_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_nxt   = ST_PLAY;
          restart_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
        if (lose) begin
          lives_nxt = lives - 2'd1;
          state_nxt = (lives == 2'd1) ? ST_GAME_OVER : ST_HOLD_LOSE;
        end else if (win) begin
          score_nxt = score_win;
          level_nxt = level_inc;
          state_nxt = ST_HOLD_WIN;
        end
      end
      ST_HOLD_WIN, ST_HOLD_LOSE: begin
        if (hold_done) begin
          state_nxt   = ST_PLAY;
          restart_nxt = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (start_edge) begin
          state_nxt   = ST_PLAY;
          restart_nxt = 1'b1;
          lives_nxt   = 2'(LIVES_INIT);
          level_nxt   = '0;
          score_nxt   = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they land with the state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ST_IDLE;
      run          <= 1'b0;
      frog_restart <= 1'b0;
      lives        <= 2'(LIVES_INIT);
      level        <= '0;
      speed        <= 4'd1;
      score        <= '0;
      banner       <= BANNER_NONE;
      game_over    <= 1'b0;
    end else begin
      state        <= state_nxt;
      run          <= (state_nxt == ST_PLAY);
      frog_restart <= restart_nxt;
      lives        <= lives_nxt;
      level        <= level_nxt;
      speed        <= 4'(level_nxt) + 4'd1;
      score        <= score_nxt;
      banner       <= banner_of(state_nxt);
      game_over    <= (state_nxt == ST_GAME_OVER);
    end
  end

endmodule
